// File: rtl/imm_encoder.sv
// RV32 immediate encoder: the inverse of decode-stage immediate extraction.
// S1 masks the base word, packs the immediate bits into their instruction
// positions and range-checks the value. S2 merges them and drives the outputs.
// A saturating counter tallies errored words as they are delivered.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_imm_type,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] TYPE_NONE = 3'b000;
    localparam logic [2:0] TYPE_I    = 3'b001;
    localparam logic [2:0] TYPE_S    = 3'b010;
    localparam logic [2:0] TYPE_B    = 3'b011;
    localparam logic [2:0] TYPE_J    = 3'b100;
    localparam logic [2:0] TYPE_U    = 3'b101;

    logic        ext_err;
    logic [31:0] ext_mask;
    logic [31:0] ext_imm;

    logic        s1_valid;
    logic        s1_err;
    logic [31:0] s1_base;
    logic [31:0] s1_imm;
    logic        s1_ready;

    logic        s2_valid;
    logic        s2_err;
    logic [31:0] s2_instr;
    logic        s2_ready;

    logic [CNT_W-1:0] err_count_r;

    // Ready propagates backwards combinationally so a full pipe still streams
    // one word per cycle when the consumer is ready.
    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // Per-type immediate field placement, base-word mask and range check.
    // Out-of-range values are still packed from their low bits.
    always_comb begin
        ext_mask = 32'h0000_0000;
        ext_imm  = 32'h0000_0000;
        ext_err  = 1'b0;
        case (in_imm_type)
            TYPE_NONE: begin
                ext_mask = 32'h0000_0000;
                ext_imm  = 32'h0000_0000;
                ext_err  = 1'b0;
            end
            TYPE_I: begin
                ext_mask = 32'hFFF0_0000;
                ext_imm  = {in_imm[11:0], 20'b0};
                ext_err  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            TYPE_S: begin
                ext_mask = 32'hFE00_0F80;
                ext_imm  = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                ext_err  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            TYPE_B: begin
                ext_mask = 32'hFE00_0F80;
                ext_imm  = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
                ext_err  = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            end
            TYPE_J: begin
                ext_mask = 32'hFFFF_F000;
                ext_imm  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
                ext_err  = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            end
            TYPE_U: begin
                ext_mask = 32'hFFFF_F000;
                ext_imm  = {in_imm[31:12], 12'b0};
                ext_err  = |in_imm[11:0];
            end
            default: begin
                // Reserved type codes pass the base through but are flagged.
                ext_mask = 32'h0000_0000;
                ext_imm  = 32'h0000_0000;
                ext_err  = 1'b1;
            end
        endcase
    end

    // Stage 1: capture masked base, packed immediate and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_base  <= 32'h0000_0000;
            s1_imm   <= 32'h0000_0000;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_err  <= ext_err;
                s1_base <= in_base & ~ext_mask;
                s1_imm  <= ext_imm;
            end
        end
    end

    // Stage 2: merge into the final word; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_instr <= 32'h0000_0000;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_err   <= s1_err;
                s2_instr <= s1_base | s1_imm;
            end
        end
    end

    // Count errored words on delivery; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= '0;
        end else if (s2_valid && out_ready && s2_err && (err_count_r != '1)) begin
            err_count_r <= err_count_r + CNT_W'(1);
        end
    end

    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases, back-pressure, a
// randomized stream against a bit-placement reference model, counter
// saturation on a narrow-counter instance, and reset with words in flight.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_imm = '0;
    logic [2:0]  in_imm_type = '0;
    logic [31:0] in_base = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;

    logic        in_ready_w2;
    logic        out_valid_w2;
    logic [31:0] out_instr_w2;
    logic        out_err_w2;
    logic [1:0]  err_count_w2;

    int n_vec = 0;
    int n_bad = 0;

    logic [32:0] sb[$];
    int          cnt = 0;
    bit          hold_valid = 0;
    logic [31:0] hold_instr;
    logic        hold_err;
    bit          last_fire = 0;
    bit          dir_mode = 0;
    logic [32:0] dir_exp;
    bit          bp_random = 0;

    imm_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_imm_type(in_imm_type), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
    );

    imm_encoder #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_w2),
        .in_imm(in_imm), .in_imm_type(in_imm_type), .in_base(in_base),
        .out_valid(out_valid_w2), .out_ready(out_ready),
        .out_instr(out_instr_w2), .out_err(out_err_w2), .err_count(err_count_w2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which immediate bit lands in instruction bit b for type t (-1: base bit kept).
    function automatic int imm_src(input logic [2:0] t, input int b);
        case (t)
            3'd1: return (b >= 20) ? b - 20 : -1;
            3'd2: begin
                if (b >= 25) return b - 20;
                if (b >= 7 && b <= 11) return b - 7;
                return -1;
            end
            3'd3: begin
                if (b == 31) return 12;
                if (b >= 25) return b - 20;
                if (b >= 8 && b <= 11) return b - 7;
                if (b == 7) return 11;
                return -1;
            end
            3'd4: begin
                if (b == 31) return 20;
                if (b >= 21) return b - 20;
                if (b == 20) return 11;
                if (b >= 12) return b;
                return -1;
            end
            3'd5: return (b >= 12) ? b : -1;
            default: return -1;
        endcase
    endfunction

    // Reference: {err, instr} from value ranges and the bit-placement table.
    function automatic logic [32:0] ref_encode(input logic [31:0] imm, input logic [2:0] t,
                                               input logic [31:0] base);
        logic [31:0] instr;
        bit          err;
        longint      v;
        int          src;
        v = longint'($signed(imm));
        for (int b = 0; b < 32; b++) begin
            src = imm_src(t, b);
            instr[b] = (src >= 0) ? imm[src] : base[b];
        end
        case (t)
            3'd0: err = 0;
            3'd1, 3'd2: err = (v < -2048) || (v > 2047);
            3'd3: err = (v < -4096) || (v > 4095) || (imm[0] == 1'b1);
            3'd4: err = (v < -1048576) || (v > 1048575) || (imm[0] == 1'b1);
            3'd5: err = (imm % 4096) != 0;
            default: err = 1;
        endcase
        return {err, instr};
    endfunction

    // One clock: evaluate handshakes before the posedge, check, advance to negedge.
    task automatic step();
        logic [32:0] e;
        if (bp_random) out_ready = 1'($urandom_range(0, 1));
        #1;
        last_fire = 0;
        if (rst) begin
            sb.delete();
            cnt = 0;
            hold_valid = 0;
            @(negedge clk);
            return;
        end
        if (hold_valid) begin
            check_eq("stall_valid", {31'b0, out_valid}, 32'd1);
            check_eq("stall_instr", out_instr, hold_instr);
            check_eq("stall_err", {31'b0, out_err}, {31'b0, hold_err});
        end
        hold_valid = out_valid && !out_ready;
        hold_instr = out_instr;
        hold_err   = out_err;
        check_eq("err_count", {16'b0, err_count}, 32'(cnt));
        check_eq("err_count_w2", {30'b0, err_count_w2}, (cnt > 3) ? 32'd3 : 32'(cnt));
        check_eq("w2_out_valid", {31'b0, out_valid_w2}, {31'b0, out_valid});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("out_instr", out_instr, e[31:0]);
                check_eq("out_err", {31'b0, out_err}, {31'b0, e[32]});
                if (e[32] && cnt < 65535) cnt++;
            end
        end else if (out_valid == 1'b0 && sb.size() == 0) begin
            check_eq("idle_out_valid", {31'b0, out_valid}, 32'd0);
        end
        if (in_valid && in_ready) begin
            last_fire = 1;
            sb.push_back(dir_mode ? dir_exp : ref_encode(in_imm, in_imm_type, in_base));
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                        input bit use_dir, input logic [32:0] exp);
        in_valid = 1'b1;
        in_imm_type = t;
        in_imm = imm;
        in_base = base;
        dir_mode = use_dir;
        dir_exp = exp;
        last_fire = 0;
        for (int i = 0; i < 50 && !last_fire; i++) step();
        if (!last_fire) check_eq("send_timeout", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        dir_mode = 0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) step();
        step();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return $urandom & 32'hFFFF_F000;
            default: return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'($urandom_range(0, 1));
        endcase
    endfunction

    initial begin
        @(negedge clk);
        step();
        do_reset();
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_err", {31'b0, out_err}, 32'd0);
        check_eq("rst_err_count", {16'b0, err_count}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // I-type with latency check
        out_ready = 1'b1;
        send(3'd1, 32'hFFFF_F800, 32'h0000_0013, 1, {1'b0, 32'h8000_0013});
        check_eq("lat_cycle1", {31'b0, out_valid}, 32'd0);
        step();
        check_eq("lat_cycle2", {31'b0, out_valid}, 32'd1);
        drain();

        send(3'd3, 32'h0000_0FFE, 32'h0000_0063, 1, {1'b0, 32'h7E00_0FE3});
        send(3'd3, 32'h0000_1001, 32'h0000_0063, 0, '0);
        drain();
        check_eq("b_err_count", {16'b0, err_count}, 32'd1);

        send(3'd4, 32'hFFFF_FFFE, 32'h0000_006F, 1, {1'b0, 32'hFFFF_F06F});
        send(3'd5, 32'h1234_5000, 32'h0000_0037, 1, {1'b0, 32'h1234_5037});
        send(3'd5, 32'h1234_5001, 32'h0000_0037, 0, '0);
        send(3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 1, {1'b0, 32'h01FF_F07F});
        send(3'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1, {1'b0, 32'hFFFF_FFFF});
        send(3'd7, 32'h1234_5678, 32'hFFFF_FFFF, 1, {1'b1, 32'hFFFF_FFFF});
        drain();

        // In-ready back-pressure
        out_ready = 1'b0;
        send(3'd1, 32'd5, 32'h0000_0013, 0, '0);
        send(3'd1, 32'd6, 32'h0000_0013, 0, '0);
        in_valid = 1'b1;
        #1;
        check_eq("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        step();
        step();
        check_eq("bp_in_ready_still_low", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_high", {31'b0, in_ready}, 32'd1);
        drain();

        // Five back-to-back words with random out_ready
        bp_random = 1;
        for (int k = 0; k < 5; k++)
            send(3'($urandom_range(0, 7)), rand_imm(), $urandom, 0, '0);
        bp_random = 0;
        drain();

        // Randomized stream
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_fire) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_imm_type = 3'($urandom_range(0, 7));
                in_imm = rand_imm();
                in_base = $urandom;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        // Saturation of the 2-bit counter
        do_reset();
        for (int k = 0; k < 5; k++) send(3'd6, $urandom, $urandom, 0, '0);
        drain();
        check_eq("sat_w2", {30'b0, err_count_w2}, 32'd3);
        check_eq("sat_w16", {16'b0, err_count}, 32'd5);

        // Reset with two words in flight
        out_ready = 1'b0;
        send(3'd7, 32'd1, 32'h0000_0013, 0, '0);
        send(3'd7, 32'd2, 32'h0000_0013, 0, '0);
        step();
        check_eq("inflight_valid", {31'b0, out_valid}, 32'd1);
        do_reset();
        check_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("mid_rst_err_count", {16'b0, err_count}, 32'd0);
        check_eq("mid_rst_err_count_w2", {30'b0, err_count_w2}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("post_rst_no_out", {31'b0, out_valid}, 32'd0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
